cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: miss  in  1  line miss from tag unit, level, held until refill completes.
REQ-004 SHALL have: write_back  in  1  victim dirty/valid, meaningful only while miss=1.
REQ-005 SHALL have: raddr  in  32  line-aligned refill address.
REQ-006 SHALL have: waddr  in  32  line-aligned victim address.
REQ-007 SHALL have: victim_data  in  256  victim line, word0 in [31:0].
REQ-008 SHALL have: flush  in  1  pipeline flush.
REQ-009 SHALL have: refresh  out  1  one-cycle pulse: write tag and refill_data into cache.
REQ-010 SHALL have: refill_data  out  256  assembled line, word0 in [31:0].
REQ-011 SHALL have: busy  out  1  high whenever state != IDLE.
REQ-012 SHALL have AXI read: araddr out 32, arvalid out 1, arready in 1, rdata in 32, rlast in 1, rvalid in 1, rready out 1.
REQ-013 SHALL have AXI write: awaddr out 32, awvalid out 1, awready in 1, wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1, bvalid in 1, bready out 1.
REQ-014 SHALL have constant outputs arlen=awlen=8'd7, arsize=awsize=3'd2, arburst=awburst=2'b01, wstrb=4'hF.

Function
REQ-015 SHALL implement states IDLE, AW, W, B, AR, R, FILL, SETTLE.
REQ-016 In IDLE with miss=1, flush=0: SHALL latch raddr, waddr, victim_data; next state AW if write_back=1, else AR.
REQ-017 In IDLE with flush=1: SHALL stay IDLE regardless of miss.
REQ-018 Once out of IDLE, flush SHALL be ignored; no AXI transaction is aborted.
REQ-019 AW: awvalid=1, awaddr=latched waddr; on awvalid&awready -> W; awvalid SHALL not drop before handshake.
REQ-020 W: 8 beats, beat counter 0..7, wdata=latched word[counter]; wvalid=1; counter increments on wvalid&wready; wlast=1 only at counter=7; after beat 7 handshake -> B.
REQ-021 B: bready=1; on bvalid -> AR; bresp ignored.
REQ-022 AR: arvalid=1, araddr=latched raddr; on arvalid&arready -> R.
REQ-023 R: rready=1; each rvalid beat stores rdata into refill_data word[counter], counter increments; beat with rlast=1 (or counter=7) -> FILL; counter cleared on entry to W and R.
REQ-024 FILL: refresh=1 for exactly this one cycle; refill_data stable and complete; -> SETTLE.
REQ-025 SETTLE: 2 cycles with miss ignored (tag RAM read latency), then IDLE.
REQ-026 Write-back SHALL always complete (B received) before AR is issued.
REQ-027 At most one valid among awvalid, wvalid, arvalid at any cycle; bready/rready high only in B/R.
REQ-028 Beats with valid low SHALL not advance counter or data; arbitrary ready/valid stalls permitted.
REQ-029 Latency with zero-wait AXI, no write-back: miss sampled at edge 0 -> arvalid cycle 1 -> R cycles 2..9 -> refresh cycle 10.

Reset
REQ-030 On rst=1 (any cycle, mid-burst included): state IDLE, counter 0, refresh/arvalid/rready/awvalid/wvalid/wlast/bready/busy=0, refill_data and latched registers 0, asynchronously.
REQ-031 After rst deasserts, a new miss SHALL start a fresh transaction from REQ-016.

Verification
REQ-032 Clean miss, write_back=0, raddr=0x1FC0_0020, zero-wait AXI, rdata=0x11..0x88 -> araddr=0x1FC0_0020, refresh one cycle at cycle 10, refill_data word0=0x11, word7=0x88.
REQ-033 Dirty miss, waddr=0x0000_1040, victim words 0xA0..0xA7 -> 8 W beats in order, wlast on 0xA7 only, arvalid not before bvalid, then refill as REQ-032.
REQ-034 Random awready/wready/arready/rvalid stalls (0-5 cycles) -> identical data, one refresh pulse, valids held until handshake.
REQ-035 flush=1 with miss=1 in IDLE -> no arvalid/awvalid; flush asserted during R -> burst completes, refresh still pulses.
REQ-036 rst asserted at R beat 4 -> all outputs 0 immediately; after release, new miss refills correctly with counter from 0.

Source files
------------

// File: rtl/cache_refill_ctrl_if.sv
// AXI4 read/write channel bundle between the refill controller (master) and memory (slave).
// Single-outstanding, fixed 8-beat INCR bursts of 32-bit words.
interface cache_refill_ctrl_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, arlen, arsize, arburst, rready,
    output awaddr, awvalid, awlen, awsize, awburst,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rlast, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arvalid, arlen, arsize, arburst, rready,
    input  awaddr, awvalid, awlen, awsize, awburst,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rlast, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: optional dirty-victim write-back burst, then an
// 8-word read burst assembled into refill_data and committed with a one-cycle refresh.
module cache_refill_ctrl (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss,
  input  logic                write_back,
  input  logic [31:0]         raddr,
  input  logic [31:0]         waddr,
  input  logic [255:0]        victim_data,
  input  logic                flush,
  output logic                refresh,
  output logic [255:0]        refill_data,
  output logic                busy,
  cache_refill_ctrl_if.master axi
);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FILL, SETTLE} state_t;

  state_t       state;
  logic [2:0]   cnt;
  logic         settle;
  logic [31:0]  raddr_q;
  logic [31:0]  waddr_q;
  logic [255:0] victim_q;

  assign axi.arlen   = 8'd7;
  assign axi.awlen   = 8'd7;
  assign axi.arsize  = 3'd2;
  assign axi.awsize  = 3'd2;
  assign axi.arburst = 2'b01;
  assign axi.awburst = 2'b01;
  assign axi.wstrb   = 4'hF;

  assign axi.araddr  = raddr_q;
  assign axi.awaddr  = waddr_q;
  assign axi.wdata   = victim_q[{cnt, 5'd0} +: 32];
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      settle      <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      victim_q    <= '0;
      refill_data <= '0;
      refresh     <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.wlast   <= 1'b0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
    end else begin
      refresh <= 1'b0;
      case (state)
        IDLE: begin
          if (miss && !flush) begin
            raddr_q  <= raddr;
            waddr_q  <= waddr;
            victim_q <= victim_data;
            if (write_back) begin
              state       <= AW;
              axi.awvalid <= 1'b1;
            end else begin
              state       <= AR;
              axi.arvalid <= 1'b1;
            end
          end
        end
        AW: begin
          if (axi.awready) begin
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b1;
            axi.wlast   <= 1'b0;
            cnt         <= '0;
            state       <= W;
          end
        end
        // wlast is registered one beat ahead so it rises together with word 7
        W: begin
          if (axi.wready) begin
            if (cnt == 3'd7) begin
              axi.wvalid <= 1'b0;
              axi.wlast  <= 1'b0;
              axi.bready <= 1'b1;
              state      <= B;
            end else begin
              cnt       <= cnt + 3'd1;
              axi.wlast <= (cnt == 3'd6);
            end
          end
        end
        B: begin
          if (axi.bvalid) begin
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b1;
            state       <= AR;
          end
        end
        AR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            cnt         <= '0;
            state       <= R;
          end
        end
        R: begin
          if (axi.rvalid) begin
            refill_data[{cnt, 5'd0} +: 32] <= axi.rdata;
            cnt <= cnt + 3'd1;
            if (axi.rlast || cnt == 3'd7) begin
              axi.rready <= 1'b0;
              refresh    <= 1'b1;
              state      <= FILL;
            end
          end
        end
        FILL: begin
          settle <= 1'b0;
          state  <= SETTLE;
        end
        // two cycles for the tag RAM to return the freshly written line
        SETTLE: begin
          if (settle) state <= IDLE;
          else        settle <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomised scoreboard bench for cache_refill_ctrl with a behavioural AXI memory slave.
module tb_cache_refill_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         miss;
  logic         write_back;
  logic [31:0]  raddr;
  logic [31:0]  waddr;
  logic [255:0] victim_data;
  logic         flush;
  logic         refresh;
  logic [255:0] refill_data;
  logic         busy;

  cache_refill_ctrl_if axi();

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss(miss), .write_back(write_back),
    .raddr(raddr), .waddr(waddr), .victim_data(victim_data), .flush(flush),
    .refresh(refresh), .refill_data(refill_data), .busy(busy), .axi(axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // expectations pushed by stimulus, popped by the monitor
  logic [31:0]  exp_aw_q[$];
  logic [31:0]  exp_ar_q[$];
  logic [32:0]  exp_w_q[$];
  logic [255:0] exp_line_q[$];

  logic [31:0]  rd_words[8];
  bit           stall_en, cur_wb, b_done, b_pending, r_active, check_lat, ar_seen;
  int unsigned  r_idx, refresh_cnt, t0;
  bit           prev_refresh, prev_aw_stall, prev_w_stall, prev_ar_stall;
  logic [31:0]  prev_awaddr, prev_araddr;
  logic [32:0]  prev_w;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  function automatic bit rnd_ready();
    return stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
  endfunction

  // memory slave + monitor: drive inputs for the coming edge, then judge what that edge will see
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0;
    axi.rvalid = 0; axi.rdata = '0; axi.rlast = 0;
    forever begin
      @(negedge clk);
      axi.awready = rnd_ready();
      axi.wready  = rnd_ready();
      axi.arready = rnd_ready();
      axi.bvalid  = b_pending && rnd_ready();
      axi.rvalid  = r_active && rnd_ready();
      axi.rdata   = axi.rvalid ? rd_words[r_idx] : $urandom;
      axi.rlast   = axi.rvalid && (r_idx == 7);
      if (rst) begin
        prev_refresh = 0; prev_aw_stall = 0; prev_w_stall = 0; prev_ar_stall = 0;
      end else begin
        if (prev_aw_stall) chk("awvalid_held", {axi.awvalid, axi.awaddr}, {1'b1, prev_awaddr});
        if (prev_ar_stall) chk("arvalid_held", {axi.arvalid, axi.araddr}, {1'b1, prev_araddr});
        if (prev_w_stall)  chk("wvalid_held", {axi.wvalid, axi.wlast, axi.wdata}, {1'b1, prev_w});
        chk("one_valid", (int'(axi.awvalid) + int'(axi.wvalid) + int'(axi.arvalid)) <= 1, 1);
        if (axi.bready) chk("bready_in_b", b_pending, 1);
        if (axi.rready) chk("rready_in_r", r_active, 1);
        if (check_lat && axi.arvalid && !ar_seen) begin
          ar_seen = 1;
          chk("ar_latency", cyc - t0, 1);
        end
        if (axi.awvalid && axi.awready) begin
          chk("aw_expected", exp_aw_q.size() != 0, 1);
          if (exp_aw_q.size() != 0) chk("awaddr", axi.awaddr, exp_aw_q.pop_front());
        end
        if (axi.wvalid && axi.wready) begin
          chk("w_expected", exp_w_q.size() != 0, 1);
          if (exp_w_q.size() != 0) chk("wbeat", {axi.wlast, axi.wdata}, exp_w_q.pop_front());
          if (axi.wlast) b_pending = 1;
        end
        if (axi.bvalid && axi.bready) begin
          b_pending = 0;
          b_done = 1;
        end
        if (axi.arvalid && axi.arready) begin
          chk("ar_after_b", !cur_wb || b_done, 1);
          chk("ar_expected", exp_ar_q.size() != 0, 1);
          if (exp_ar_q.size() != 0) chk("araddr", axi.araddr, exp_ar_q.pop_front());
          r_active = 1;
          r_idx = 0;
        end
        if (axi.rvalid && axi.rready) begin
          r_idx++;
          if (r_idx == 8) r_active = 0;
        end
        if (refresh) begin
          refresh_cnt++;
          chk("refresh_pulse", prev_refresh, 0);
          chk("line_expected", exp_line_q.size() != 0, 1);
          if (exp_line_q.size() != 0) chk("refill_data", refill_data, exp_line_q.pop_front());
          if (check_lat) chk("refresh_latency", cyc - t0, 10);
        end
        prev_refresh  = refresh;
        prev_aw_stall = axi.awvalid && !axi.awready;
        prev_ar_stall = axi.arvalid && !axi.arready;
        prev_w_stall  = axi.wvalid && !axi.wready;
        prev_awaddr   = axi.awaddr;
        prev_araddr   = axi.araddr;
        prev_w        = {axi.wlast, axi.wdata};
      end
    end
  end

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {refresh, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
                         axi.wlast, axi.bready, busy}, 8'h00);
    chk({tag, "_refill"}, refill_data, 256'h0);
    chk({tag, "_addr"}, {axi.araddr, axi.awaddr}, 64'h0);
  endtask

  task automatic issue(input bit wb, input logic [31:0] ra, input logic [31:0] wa,
                       input logic [255:0] vic, input logic [255:0] line);
    for (int i = 0; i < 8; i++) rd_words[i] = line[i*32 +: 32];
    if (wb) begin
      exp_aw_q.push_back(wa);
      for (int i = 0; i < 8; i++) exp_w_q.push_back({(i == 7), vic[i*32 +: 32]});
    end
    exp_ar_q.push_back(ra);
    exp_line_q.push_back(line);
    cur_wb = wb; b_done = 0; ar_seen = 0; t0 = cyc;
    miss = 1; write_back = wb; raddr = ra; waddr = wa; victim_data = vic;
  endtask

  // fmode: 0 no flush, 1 random flush, 2 flush held while busy
  task automatic wait_done(input int fmode);
    int unsigned start = refresh_cnt;
    int n = 0;
    while (refresh_cnt == start && n < 400) begin
      @(negedge clk); #1; n++;
      if (busy) begin
        raddr = $urandom; waddr = $urandom; victim_data = rnd_line(); write_back = $urandom_range(0, 1);
        flush = (fmode == 2) ? 1'b1 : (fmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    chk("refill_done", refresh_cnt - start, 1);
    miss = 0; flush = 0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); #1; n++; end
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    logic [255:0] vic, line;
    int n;
    rst = 1; miss = 0; write_back = 0; raddr = '0; waddr = '0; victim_data = '0; flush = 0;
    stall_en = 0; check_lat = 0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk); #1; rst = 0;
    @(negedge clk); #1;

    // clean miss, zero-wait, latency checked
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = 32'h11 * (i + 1);
    check_lat = 1;
    issue(0, 32'h1FC0_0020, 32'h0, 256'h0, line);
    wait_done(0);
    check_lat = 0;
    chk("word0", refill_data[31:0], 32'h11);
    chk("word7", refill_data[255:224], 32'h88);

    // dirty miss
    for (int i = 0; i < 8; i++) vic[i*32 +: 32] = 32'hA0 + i;
    issue(1, 32'h1FC0_0020, 32'h0000_1040, vic, line);
    wait_done(0);

    // flush in IDLE blocks the miss
    @(negedge clk); #1;
    miss = 1; flush = 1; write_back = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("flush_idle", {busy, axi.arvalid, axi.awvalid}, 3'b000);
    end
    miss = 0; flush = 0;
    @(negedge clk); #1;

    // flush held throughout a refill is ignored
    issue(1, $urandom & ~32'h1F, $urandom & ~32'h1F, rnd_line(), rnd_line());
    wait_done(2);

    // random traffic with stalls and flush noise
    for (int t = 0; t < 30; t++) begin
      stall_en = $urandom_range(0, 1);
      @(negedge clk); #1;
      issue($urandom_range(0, 1), $urandom & ~32'h1F, $urandom & ~32'h1F, rnd_line(), rnd_line());
      wait_done(1);
    end

    // reset in the middle of the read burst
    stall_en = 0;
    @(negedge clk); #1;
    issue(1, $urandom & ~32'h1F, $urandom & ~32'h1F, rnd_line(), rnd_line());
    n = 0;
    while (!(r_active && r_idx == 4) && n < 200) begin @(negedge clk); #1; n++; end
    chk("reached_beat4", r_idx, 4);
    rst = 1;
    #1;
    check_reset_outputs("midburst_reset");
    exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete(); exp_line_q.delete();
    r_active = 0; r_idx = 0; b_pending = 0; b_done = 0;
    miss = 0;
    @(negedge clk); #1; rst = 0;
    @(negedge clk); #1;
    issue(0, $urandom & ~32'h1F, 32'h0, 256'h0, rnd_line());
    wait_done(0);
    stall_en = 1;
    @(negedge clk); #1;
    issue(1, $urandom & ~32'h1F, $urandom & ~32'h1F, rnd_line(), rnd_line());
    wait_done(0);

    @(negedge clk); #1;
    chk("queues_drained", exp_aw_q.size() + exp_ar_q.size() + exp_w_q.size() + exp_line_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
